m3_round_len_calc: RTL and testbench

//  Upstream stage of the m3 step sequencer: owns the per-step slice length (dstRoundLenO) it reloads each step.

---
 rtl/m3_pkg.sv | 22 ++
 rtl/m3_len_ramp.sv | 36 +++
 rtl/m3_round_len_calc.sv | 108 ++++++++++
 tb/tb_m3_round_len_calc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m3_pkg.sv
// Shared m3 types and default slice-length constants for the step sequencer front end.
package m3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2,
      HALT = 2'd3
   } m3State_t;

   localparam int LEN_W = 22;
   typedef logic [LEN_W-1:0] len_t;

   localparam len_t eachSlicePeriodMax = 22'h3FFFFF;

   localparam len_t LEN_START_DEF  = 22'd200000;
   localparam len_t LEN_MIN_DEF    = 22'd2000;
   localparam len_t LEN_MAX_DEF    = 22'd400000;
   localparam len_t LEN_STEP_DEF   = 22'd1000;
   localparam len_t RAMP_DELTA_DEF = 22'd500;

endpackage

// File: rtl/m3_len_ramp.sv
// One ramp step of the live slice length toward its target, never overshooting.
// M3_LEN_RAMP_EN: step limited to deltaI; undefined: jump straight to target.
module m3_len_ramp
   import m3_pkg::*;
(
   input  len_t curI,
   input  len_t tgtI,
   input  len_t deltaI,
   output len_t nxtO,
   output logic changedO
);

   logic signed [LEN_W:0] diff;
   logic signed [LEN_W:0] negDiff;
   len_t                  mag;
   len_t                  step;

   always_comb begin
      diff    = $signed({1'b0, tgtI}) - $signed({1'b0, curI});
      negDiff = -diff;
      mag     = diff[LEN_W] ? negDiff[LEN_W-1:0] : diff[LEN_W-1:0];
`ifdef M3_LEN_RAMP_EN
      step    = (mag > deltaI) ? deltaI : mag;
`else
      step    = mag;
`endif
      nxtO     = diff[LEN_W] ? (curI - step) : (curI + step);
      changedO = (mag != '0);
   end

`ifndef M3_LEN_RAMP_EN
   logic unusedDelta;
   assign unusedDelta = ^deltaI;
`endif

endmodule

// File: rtl/m3_round_len_calc.sv
// Slice-length owner for the m3 sequencer: speed commands set a target, nextCalc ramps toward it.
// Optional M3_LEN_RAMP_EN limits each ramp step to RAMP_DELTA.
module m3_round_len_calc
   import m3_pkg::*;
#(
   parameter len_t LEN_START  = LEN_START_DEF,
   parameter len_t LEN_MIN    = LEN_MIN_DEF,
   parameter len_t LEN_MAX    = LEN_MAX_DEF,
   parameter len_t LEN_STEP   = LEN_STEP_DEF,
   parameter len_t RAMP_DELTA = RAMP_DELTA_DEF
) (
   input  logic        clkI,
   input  logic        nRstI,
   input  logic        m3startI,
   input  logic        m3forceStopI,
   input  logic        m3speedINCi,
   input  logic        m3speedDECi,
   input  logic        nextCalc_1i,
   output logic [31:0] dstRoundLenO,
   output logic        lenUpdO,
   output logic        atTargetO,
   output logic        stopDoneO
);

   m3State_t              state, nextState;
   len_t                  cur, tgt, nxtCur, nxtTgt, rampCur;
   logic                  incPrev, decPrev, incEdge, decEdge;
   logic                  rampChg, stepEn;
   logic                  nxtLenUpd, nxtAtTarget, nxtStopDone;
   logic signed [LEN_W:0] tgtDn;
   logic        [LEN_W:0] tgtUp;

   assign incEdge      = m3speedINCi & ~incPrev;
   assign decEdge      = m3speedDECi & ~decPrev;
   assign stepEn       = nextCalc_1i & ((state == RUN) | (state == STOP));
   assign dstRoundLenO = {{(32-LEN_W){1'b0}}, cur};

   m3_len_ramp uRamp (
      .curI     (cur),
      .tgtI     (tgt),
      .deltaI   (RAMP_DELTA),
      .nxtO     (rampCur),
      .changedO (rampChg)
   );

   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         state     <= IDLE;
         cur       <= LEN_START;
         tgt       <= LEN_START;
         incPrev   <= 1'b0;
         decPrev   <= 1'b0;
         lenUpdO   <= 1'b0;
         atTargetO <= 1'b1;
         stopDoneO <= 1'b0;
      end else begin
         state     <= nextState;
         cur       <= nxtCur;
         tgt       <= nxtTgt;
         incPrev   <= m3speedINCi;
         decPrev   <= m3speedDECi;
         lenUpdO   <= nxtLenUpd;
         atTargetO <= nxtAtTarget;
         stopDoneO <= nxtStopDone;
      end
   end

   // Dropping start always wins and discards any ramp in progress.
   always_comb begin
      nextState = state;
      if (!m3startI) begin
         nextState = IDLE;
      end else begin
         case (state)
            IDLE: nextState = RUN;
            RUN:  if (m3forceStopI) nextState = STOP;
            STOP: if (nxtCur == LEN_MAX) nextState = HALT;
            HALT: nextState = HALT;
            default: nextState = IDLE;
         endcase
      end
   end

   // Ramp sees the target from before this cycle's command is applied.
   always_comb begin
      tgtDn     = $signed({1'b0, tgt}) - $signed({1'b0, LEN_STEP});
      tgtUp     = {1'b0, tgt} + {1'b0, LEN_STEP};
      nxtCur    = stepEn ? rampCur : cur;
      nxtTgt    = tgt;
      nxtLenUpd = stepEn & rampChg;
      if (state == RUN) begin
         if (m3forceStopI)
            nxtTgt = LEN_MAX;
         else if (incEdge & ~decEdge)
            nxtTgt = (tgtDn < $signed({1'b0, LEN_MIN})) ? LEN_MIN : tgtDn[LEN_W-1:0];
         else if (decEdge & ~incEdge)
            nxtTgt = (tgtUp > {1'b0, LEN_MAX}) ? LEN_MAX : tgtUp[LEN_W-1:0];
      end
      if (!m3startI) begin
         nxtCur    = LEN_START;
         nxtTgt    = LEN_START;
         nxtLenUpd = 1'b0;
      end
      nxtAtTarget = (nxtCur == nxtTgt);
      nxtStopDone = (nextState == HALT);
   end

endmodule

// File: tb/tb_m3_round_len_calc.sv
// Randomized scoreboard bench for m3_round_len_calc against an arithmetic reference model.
module tb_m3_round_len_calc;

   localparam int START = 200000;
   localparam int LMIN  = 2000;
   localparam int LMAX  = 400000;
   localparam int STEP  = 1000;
   localparam int RAMP  = 500;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        st = 1'b0, fs = 1'b0, inc = 1'b0, dec = 1'b0, nc = 1'b0;
   logic [31:0] len;
   logic        lenUpd, atTarget, stopDone;

   typedef struct {
      int len;
      bit upd;
      bit at;
      bit sd;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   // reference model: mode 0 idle, 1 running, 2 stopping, 3 halted
   int mCur = START, mTgt = START, mMode = 0;
   bit pInc = 0, pDec = 0;

   m3_round_len_calc dut (
      .clkI         (clk),
      .nRstI        (nRst),
      .m3startI     (st),
      .m3forceStopI (fs),
      .m3speedINCi  (inc),
      .m3speedDECi  (dec),
      .nextCalc_1i  (nc),
      .dstRoundLenO (len),
      .lenUpdO      (lenUpd),
      .atTargetO    (atTarget),
      .stopDoneO    (stopDone)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelEdge(bit s, bit f, bit i, bit d, bit n, output exp_t e);
      bit ie, de, upd;
      int diff;
      ie = i && !pInc;
      de = d && !pDec;
      pInc = i;
      pDec = d;
      upd = 0;
      if (!s) begin
         mMode = 0;
         mCur = START;
         mTgt = START;
      end else begin
         if (n && (mMode == 1 || mMode == 2)) begin
            diff = mTgt - mCur;
            upd = (diff != 0);
`ifdef M3_LEN_RAMP_EN
            if (diff > RAMP) diff = RAMP;
            if (diff < -RAMP) diff = -RAMP;
`endif
            mCur = mCur + diff;
         end
         if (mMode == 0) mMode = 1;
         else if (mMode == 1) begin
            if (f) begin
               mTgt = LMAX;
               mMode = 2;
            end else if (ie && !de) mTgt = (mTgt - STEP < LMIN) ? LMIN : mTgt - STEP;
            else if (de && !ie) mTgt = (mTgt + STEP > LMAX) ? LMAX : mTgt + STEP;
         end else if (mMode == 2) begin
            if (mCur == LMAX) mMode = 3;
         end
      end
      e.len = mCur;
      e.upd = upd;
      e.at  = (mCur == mTgt);
      e.sd  = (mMode == 3);
   endtask

   task automatic drive(bit s, bit f, bit i, bit d, bit n);
      exp_t e;
      @(negedge clk);
      st = s; fs = f; inc = i; dec = d; nc = n;
      modelEdge(s, f, i, d, n, e);
      expQ.push_back(e);
   endtask

   task automatic settle();
      @(posedge clk);
      #3;
   endtask

   task automatic pulseInc(int k);
      for (int j = 0; j < k; j++) begin
         drive(1, 0, 1, 0, 0);
         drive(1, 0, 0, 0, 0);
      end
   endtask

   task automatic pulseDec(int k);
      for (int j = 0; j < k; j++) begin
         drive(1, 0, 0, 1, 0);
         drive(1, 0, 0, 0, 0);
      end
   endtask

   // monitor: every edge following a driven cycle yields one expected response
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("len", int'(len), e.len);
            chk("lenUpd", int'(lenUpd), int'(e.upd));
            chk("atTarget", int'(atTarget), int'(e.at));
            chk("stopDone", int'(stopDone), int'(e.sd));
         end
      end
   end

   initial begin
      int cnt;
      bit rs, rf, ri, rd, rn;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_len", int'(len), START);
      chk("rst_upd", int'(lenUpd), 0);
      chk("rst_at", int'(atTarget), 1);
      chk("rst_sd", int'(stopDone), 0);
      @(negedge clk);
      nRst = 1'b1;

      // idle start-up, strobes with nothing to do
      for (int j = 0; j < 6; j++) drive(1, 0, 0, 0, j % 2);

      // three INC edges then ramp to 197000
      pulseInc(3);
      for (int j = 0; j < 8; j++) begin
         drive(1, 0, 0, 0, 1);
         drive(1, 0, 0, 0, 0);
      end
      settle();
      chk("t2_len", int'(len), 197000);
      chk("t2_at", int'(atTarget), 1);

      // drive target to the minimum, then simultaneous INC+DEC
      pulseInc(200);
      drive(1, 0, 1, 1, 0);
      drive(1, 0, 0, 0, 0);
      cnt = 0;
      while (mCur != LMIN && cnt < 1000) begin
         drive(1, 0, 0, 0, 1);
         cnt++;
      end
      drive(1, 0, 0, 0, 0);
      settle();
      chk("t3_len", int'(len), LMIN);
      chk("t3_at", int'(atTarget), 1);

      // force-stop spin-down from the minimum length
      drive(1, 1, 0, 0, 0);
      cnt = 0;
      do begin
         drive(1, 1, 0, 0, 1);
         cnt++;
         settle();
      end while (!stopDone && cnt < 2000);
`ifdef M3_LEN_RAMP_EN
      chk("t4_strobes", cnt, 796);
`else
      chk("t4_strobes", cnt, 1);
`endif
      chk("t4_len", int'(len), LMAX);
      drive(1, 1, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      settle();
      chk("t4_idle_len", int'(len), START);
      chk("t4_idle_sd", int'(stopDone), 0);

      // DEC saturation at the maximum
      drive(1, 0, 0, 0, 0);
      pulseDec(210);
      cnt = 0;
      while (mCur != LMAX && cnt < 1000) begin
         drive(1, 0, 0, 0, 1);
         cnt++;
      end
      pulseDec(2);
      drive(1, 0, 0, 0, 1);
      settle();
      chk("t3_max_len", int'(len), LMAX);
      chk("t3_max_upd", int'(lenUpd), 0);

      // start dropped mid-ramp together with a strobe
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      pulseInc(5);
      drive(1, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      settle();
      chk("t5_len", int'(len), START);
      chk("t5_upd", int'(lenUpd), 0);

      // ten INCs then a single strobe
      drive(1, 0, 0, 0, 0);
      pulseInc(10);
      drive(1, 0, 0, 0, 1);
      settle();
`ifdef M3_LEN_RAMP_EN
      chk("t6_len", int'(len), 199500);
`else
      chk("t6_len", int'(len), 190000);
`endif
      chk("t6_upd", int'(lenUpd), 1);
      drive(1, 0, 0, 0, 0);
      settle();
      chk("t6_upd_off", int'(lenUpd), 0);

      // randomized traffic
      rf = 0;
      for (int j = 0; j < 5000; j++) begin
         rs = ($urandom_range(0, 249) != 0);
         rf = ($urandom_range(0, 299) == 0) ? 1'b1 : (rf && ($urandom_range(0, 49) != 0));
         ri = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 4) == 0);
         rn = ($urandom_range(0, 2) == 0);
         drive(rs, rf, ri, rd, rn);
      end

      repeat (3) @(posedge clk);
      #3;
      chk("queue_drained", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
